// File: rtl/spi_slave_burst.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : spi_slave_burst
//  Purpose  : Oversampled SPI slave with multi-word bursts and a valid/ready
//             TX word interface.
//  Revision : 1.0
// ============================================================================
module spi_slave_burst #(
  parameter int DATA_WIDTH  = 16,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_sdi,
  output logic                  spi_sdo,
  output logic                  spi_sdo_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  tx_underrun
);

  localparam int                 c_BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sck_prev;
  logic                   r_cs_prev;

  logic [DATA_WIDTH-1:0]  r_tx_shift;
  logic [DATA_WIDTH-1:0]  r_rx_shift;
  logic [DATA_WIDTH-1:0]  r_rx_data;
  logic [c_BIT_W-1:0]     r_bit_cnt;
  logic [CNT_WIDTH-1:0]   r_word_cnt;
  logic                   r_sdo;
  logic                   r_sdo_oe;
  logic                   r_word_done;
  logic                   r_rx_valid;

  logic                   w_sck;
  logic                   w_cs;
  logic                   w_sdi;
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic                   w_lead_edge;
  logic                   w_trail_edge;
  logic                   w_sample_edge;
  logic                   w_shift_edge;
  logic                   w_cs_fall;
  logic                   w_word_end;
  logic                   w_load_word;
  logic                   w_to_idle;
  logic                   w_frame_start;
  logic                   w_frame_done;
  logic [DATA_WIDTH-1:0]  w_load_val;
  logic                   w_load_first;
  logic [DATA_WIDTH-1:0]  w_load_rest;
  logic                   w_tx_first;
  logic [DATA_WIDTH-1:0]  w_tx_rest;
  logic [DATA_WIDTH-1:0]  w_rx_next;

  // Input synchronisers; the *_prev flops give the edge detector its second stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync <= '0;
      r_cs_sync  <= '0;
      r_sdi_sync <= '0;
      r_sck_prev <= 1'b0;
      r_cs_prev  <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
      r_cs_prev  <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck         = r_sck_sync[SYNC_STAGES-1];
  assign w_cs          = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi         = r_sdi_sync[SYNC_STAGES-1];
  assign w_sck_rise    = w_sck & ~r_sck_prev;
  assign w_sck_fall    = ~w_sck & r_sck_prev;
  assign w_lead_edge   = (CPOL == 0) ? w_sck_rise : w_sck_fall;
  assign w_trail_edge  = (CPOL == 0) ? w_sck_fall : w_sck_rise;
  assign w_sample_edge = (CPHA == 0) ? w_lead_edge : w_trail_edge;
  assign w_shift_edge  = (CPHA == 0) ? w_trail_edge : w_lead_edge;
  assign w_cs_fall     = ~w_cs & r_cs_prev;

  assign w_word_end = (r_state == ST_ACTIVE) && w_sample_edge && (r_bit_cnt == c_LAST_BIT);
  assign w_load_val = tx_valid ? tx_data : '0;

  // The TX shift register holds only bits not yet driven onto spi_sdo.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_load_first = w_load_val[DATA_WIDTH-1];
      assign w_load_rest  = {w_load_val[DATA_WIDTH-2:0], 1'b0};
      assign w_tx_first   = r_tx_shift[DATA_WIDTH-1];
      assign w_tx_rest    = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      assign w_rx_next    = {r_rx_shift[DATA_WIDTH-2:0], w_sdi};
    end else begin : g_lsb_first
      assign w_load_first = w_load_val[0];
      assign w_load_rest  = {1'b0, w_load_val[DATA_WIDTH-1:1]};
      assign w_tx_first   = r_tx_shift[0];
      assign w_tx_rest    = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
      assign w_rx_next    = {w_sdi, r_rx_shift[DATA_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Leaving ACTIVE waits out any word still being reported so that rx_valid
  // always precedes frame_done.
  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_frame_done  = 1'b0;
    w_load_word   = 1'b0;
    w_to_idle     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_next  = ST_LOAD;
          w_frame_start = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_cs) begin
          w_state_next = ST_IDLE;
          w_frame_done = 1'b1;
          w_to_idle    = 1'b1;
        end else begin
          w_state_next = ST_ACTIVE;
          w_load_word  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_load_word = w_word_end;
        if (w_cs && !w_sample_edge && !r_word_done && !r_rx_valid) begin
          w_state_next = ST_IDLE;
          w_frame_done = 1'b1;
          w_to_idle    = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift <= '0;
      r_sdo      <= 1'b0;
      r_sdo_oe   <= 1'b0;
    end else if (w_to_idle) begin
      r_tx_shift <= '0;
      r_sdo      <= 1'b0;
      r_sdo_oe   <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_sdo_oe <= 1'b1;
      if (CPHA == 0) begin
        r_sdo      <= w_load_first;
        r_tx_shift <= w_load_rest;
      end else begin
        r_tx_shift <= w_load_val;
      end
    end else if (r_state == ST_ACTIVE) begin
      if (w_word_end) begin
        r_tx_shift <= w_load_val;
      end else if (w_shift_edge) begin
        r_sdo      <= w_tx_first;
        r_tx_shift <= w_tx_rest;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_rx_data   <= '0;
      r_word_done <= 1'b0;
      r_rx_valid  <= 1'b0;
    end else begin
      r_rx_valid  <= r_word_done;
      r_word_done <= 1'b0;
      if (w_to_idle || (r_state == ST_LOAD)) begin
        r_rx_shift <= '0;
        r_bit_cnt  <= '0;
      end else if ((r_state == ST_ACTIVE) && w_sample_edge) begin
        r_rx_shift <= w_rx_next;
        if (w_word_end) begin
          r_bit_cnt   <= '0;
          r_rx_data   <= w_rx_next;
          r_word_done <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt <= '0;
    end else if (w_frame_start) begin
      r_word_cnt <= '0;
    end else if (w_word_end && (r_word_cnt != {CNT_WIDTH{1'b1}})) begin
      r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
    end
  end

  assign spi_sdo     = r_sdo;
  assign spi_sdo_oe  = r_sdo_oe;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign word_cnt    = r_word_cnt;
  assign frame_start = w_frame_start;
  assign frame_done  = w_frame_done;
  assign tx_ready    = w_load_word & tx_valid;
  assign tx_underrun = w_load_word & ~tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_burst.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_spi_slave_burst
//  Purpose  : Directed bench for spi_slave_burst; four instances cover mode 0
//             MSB, mode 3, mode 1 and mode 0 LSB-first framing.
//  Revision : 1.0
// ============================================================================
module tb_spi_slave_burst;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        sdi = 1'b0;
  logic        sck [4];
  logic        cs_n [4];
  logic        sdo [4];
  logic        oe [4];
  logic [15:0] tx_data [4];
  logic        tx_valid [4];
  logic        tx_ready [4];
  logic [15:0] rx_data [4];
  logic        rx_valid [4];
  logic        frame_start [4];
  logic        frame_done [4];
  logic        tx_underrun [4];
  logic [7:0]  word_cnt [4];

  logic [15:0] tx_tab [4][8];
  logic        tx_vld [4][8];
  int          tx_idx [4];

  logic [15:0] mosi_tab [8];
  logic [15:0] miso_got [8];

  logic [15:0] rx_log [4][8];
  int          rx_cnt [4];
  int          ready_cnt [4];
  int          ur_cnt [4];
  int          done_cnt [4];
  int          start_cnt [4];
  int          wc_done [4];
  int          rx_t [4];
  int          done_t [4];
  int          cyc = 0;

  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int P_CPOL = (g == 1) ? 1 : 0;
      localparam int P_CPHA = (g == 1 || g == 2) ? 1 : 0;
      localparam int P_MSB  = (g == 3) ? 0 : 1;

      assign tx_data[g]  = tx_tab[g][tx_idx[g]];
      assign tx_valid[g] = tx_vld[g][tx_idx[g]];

      spi_slave_burst #(
        .DATA_WIDTH (16),
        .CPOL       (P_CPOL),
        .CPHA       (P_CPHA),
        .MSB_FIRST  (P_MSB),
        .SYNC_STAGES(2),
        .CNT_WIDTH  (8)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (sck[g]),
        .spi_cs_n   (cs_n[g]),
        .spi_sdi    (sdi),
        .spi_sdo    (sdo[g]),
        .spi_sdo_oe (oe[g]),
        .tx_data    (tx_data[g]),
        .tx_valid   (tx_valid[g]),
        .tx_ready   (tx_ready[g]),
        .rx_data    (rx_data[g]),
        .rx_valid   (rx_valid[g]),
        .frame_start(frame_start[g]),
        .frame_done (frame_done[g]),
        .word_cnt   (word_cnt[g]),
        .tx_underrun(tx_underrun[g])
      );
    end
  endgenerate

  // TX source: advance through the table on each load handshake.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (clr) begin
        tx_idx[i] <= 0;
      end else if ((tx_ready[i] || tx_underrun[i]) && tx_idx[i] < 7) begin
        tx_idx[i] <= tx_idx[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (clr) begin
        rx_cnt[i]    <= 0;
        ready_cnt[i] <= 0;
        ur_cnt[i]    <= 0;
        done_cnt[i]  <= 0;
        start_cnt[i] <= 0;
        wc_done[i]   <= -1;
        rx_t[i]      <= 0;
        done_t[i]    <= 0;
      end else begin
        if (rx_valid[i]) begin
          if (rx_cnt[i] < 8) rx_log[i][rx_cnt[i]] <= rx_data[i];
          rx_cnt[i] <= rx_cnt[i] + 1;
          rx_t[i]   <= cyc;
        end
        if (tx_ready[i])    ready_cnt[i] <= ready_cnt[i] + 1;
        if (tx_underrun[i]) ur_cnt[i]    <= ur_cnt[i] + 1;
        if (frame_start[i]) start_cnt[i] <= start_cnt[i] + 1;
        if (frame_done[i]) begin
          done_cnt[i] <= done_cnt[i] + 1;
          wc_done[i]  <= int'(word_cnt[i]);
          done_t[i]   <= cyc;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic set_tx(input int id, input int k, input logic v, input logic [15:0] d);
    tx_vld[id][k] = v;
    tx_tab[id][k] = d;
  endtask

  // One word (or its first nbits) as the MCU sees it; returns the MISO bits.
  task automatic spi_word(input int id, input logic [15:0] w, input int nbits,
                          input bit cs_last, output logic [15:0] r);
    int   bi;
    logic cpol;
    bit   cpha;
    bit   msb;
    cpol = (id == 1);
    cpha = (id == 1 || id == 2);
    msb  = (id != 3);
    r    = '0;
    for (int b = 0; b < nbits; b++) begin
      bi = msb ? 15 - b : b;
      if (!cpha) begin
        sdi = w[bi];
        #HALF;
        sck[id] = ~cpol;
        r[bi]   = sdo[id];
        #HALF;
        sck[id] = cpol;
      end else begin
        sck[id] = ~cpol;
        sdi     = w[bi];
        #HALF;
        sck[id] = cpol;
        r[bi]   = sdo[id];
        if (cs_last && b == nbits - 1) cs_n[id] = 1'b1;
        #HALF;
      end
    end
  endtask

  task automatic spi_frame(input int id, input int nwords, input int last_bits, input bit cs_last);
    logic [15:0] r;
    int          nb;
    cs_n[id] = 1'b0;
    #HALF;
    check($sformatf("oe_active_%0d", id), 32'(oe[id]), 32'd1);
    for (int w = 0; w < nwords; w++) begin
      nb = (w == nwords - 1) ? last_bits : 16;
      spi_word(id, mosi_tab[w], nb, cs_last && (w == nwords - 1), r);
      miso_got[w] = r;
    end
    #HALF;
    cs_n[id] = 1'b1;
    #(4 * HALF);
  endtask

  initial begin
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      sck[i]  = (i == 1);
      cs_n[i] = 1'b1;
      for (int k = 0; k < 8; k++) set_tx(i, k, 1'b0, 16'h0000);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sdo_oe", {30'd0, sdo[0], oe[0]}, 32'd0);
    check("rst_rx_data", rx_data[0], 32'd0);
    check("rst_word_cnt", word_cnt[0], 32'd0);
    check("rst_pulses", {rx_valid[0], tx_ready[0], tx_underrun[0], frame_start[0], frame_done[0]}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Mode 0, single word
    set_tx(0, 0, 1'b1, 16'h3C5A);
    mosi_tab[0] = 16'hA5C3;
    clear_logs();
    spi_frame(0, 1, 16, 1'b0);
    check("m0_miso", miso_got[0], 32'h3C5A);
    check("m0_rx_cnt", rx_cnt[0], 32'd1);
    check("m0_rx_data", rx_log[0][0], 32'hA5C3);
    check("m0_tx_ready", ready_cnt[0], 32'd1);
    check("m0_underrun", ur_cnt[0], 32'd1);
    check("m0_frames", {start_cnt[0][15:0], done_cnt[0][15:0]}, 32'h0001_0001);
    check("m0_word_cnt", wc_done[0], 32'd1);
    check("m0_idle_oe", {30'd0, sdo[0], oe[0]}, 32'd0);

    // Three-word burst
    set_tx(0, 0, 1'b1, 16'hAAAA);
    set_tx(0, 1, 1'b1, 16'hBBBB);
    set_tx(0, 2, 1'b1, 16'hCCCC);
    set_tx(0, 3, 1'b0, 16'h0000);
    mosi_tab[0] = 16'h1111;
    mosi_tab[1] = 16'h2222;
    mosi_tab[2] = 16'h3333;
    clear_logs();
    spi_frame(0, 3, 16, 1'b0);
    check("burst_miso0", miso_got[0], 32'hAAAA);
    check("burst_miso1", miso_got[1], 32'hBBBB);
    check("burst_miso2", miso_got[2], 32'hCCCC);
    check("burst_rx_cnt", rx_cnt[0], 32'd3);
    check("burst_rx0", rx_log[0][0], 32'h1111);
    check("burst_rx1", rx_log[0][1], 32'h2222);
    check("burst_rx2", rx_log[0][2], 32'h3333);
    check("burst_word_cnt", wc_done[0], 32'd3);
    check("burst_tx_ready", ready_cnt[0], 32'd3);

    // Underrun on the second word
    set_tx(0, 0, 1'b1, 16'hAAAA);
    set_tx(0, 1, 1'b0, 16'h5555);
    set_tx(0, 2, 1'b1, 16'hCCCC);
    mosi_tab[0] = 16'h1234;
    mosi_tab[1] = 16'h5678;
    clear_logs();
    spi_frame(0, 2, 16, 1'b0);
    check("ur_miso0", miso_got[0], 32'hAAAA);
    check("ur_miso1", miso_got[1], 32'h0000);
    check("ur_count", ur_cnt[0], 32'd1);
    check("ur_tx_ready", ready_cnt[0], 32'd2);
    check("ur_rx0", rx_log[0][0], 32'h1234);
    check("ur_rx1", rx_log[0][1], 32'h5678);

    // Mode 3 and mode 1 loopback; mode 1 raises CS on the final sample edge
    set_tx(1, 0, 1'b1, 16'h8001);
    set_tx(2, 0, 1'b1, 16'h8001);
    mosi_tab[0] = 16'h8001;
    clear_logs();
    spi_frame(1, 1, 16, 1'b0);
    check("m3_miso", miso_got[0], 32'h8001);
    check("m3_rx", rx_log[1][0], 32'h8001);
    check("m3_rx_cnt", rx_cnt[1], 32'd1);
    spi_frame(2, 1, 16, 1'b1);
    check("m1_miso", miso_got[0], 32'h8001);
    check("m1_rx", rx_log[2][0], 32'h8001);
    check("m1_word_cnt", wc_done[2], 32'd1);
    check("m1_rx_before_done", 32'(done_t[2] > rx_t[2]), 32'd1);

    // Abort after 7 bits of word 2
    set_tx(0, 0, 1'b1, 16'h1111);
    set_tx(0, 1, 1'b1, 16'h2222);
    set_tx(0, 2, 1'b0, 16'h0000);
    mosi_tab[0] = 16'h0F0F;
    mosi_tab[1] = 16'hABCD;
    clear_logs();
    spi_frame(0, 2, 7, 1'b0);
    check("abort_rx_cnt", rx_cnt[0], 32'd1);
    check("abort_rx0", rx_log[0][0], 32'h0F0F);
    check("abort_word_cnt", wc_done[0], 32'd1);
    check("abort_done", done_cnt[0], 32'd1);
    check("abort_miso0", miso_got[0], 32'h1111);

    // LSB-first frame
    set_tx(3, 0, 1'b1, 16'h1234);
    mosi_tab[0] = 16'h00F1;
    clear_logs();
    spi_frame(3, 1, 16, 1'b0);
    check("lsb_rx", rx_log[3][0], 32'h00F1);
    check("lsb_miso", miso_got[0], 32'h1234);
    check("lsb_word_cnt", wc_done[3], 32'd1);

    // Reset mid-word, then a clean frame
    set_tx(0, 0, 1'b1, 16'h5A5A);
    set_tx(0, 1, 1'b0, 16'h0000);
    clear_logs();
    cs_n[0] = 1'b0;
    #HALF;
    spi_word(0, 16'hFFFF, 5, 1'b0, r);
    rst = 1'b1;
    #1;
    check("midrst_oe", oe[0], 32'd0);
    check("midrst_sdo", sdo[0], 32'd0);
    check("midrst_rx_data", rx_data[0], 32'd0);
    check("midrst_word_cnt", word_cnt[0], 32'd0);
    #20 rst = 1'b0;
    clear_logs();
    spi_word(0, 16'hFFFF, 11, 1'b0, r);
    #HALF;
    cs_n[0] = 1'b1;
    #(4 * HALF);
    check("midrst_ignored", {rx_cnt[0][7:0], start_cnt[0][7:0], done_cnt[0][7:0]}, 32'd0);
    mosi_tab[0] = 16'h5A5A;
    clear_logs();
    spi_frame(0, 1, 16, 1'b0);
    check("postrst_rx", rx_log[0][0], 32'h5A5A);
    check("postrst_miso", miso_got[0], 32'h5A5A);
    check("postrst_word_cnt", wc_done[0], 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
